modexp_ladder: RTL and testbench

MODEXP_LADDER -- requirements
Module: modexp_ladder

---
 rtl/modexp_ladder_if.sv | 28 ++
 rtl/modexp_ladder.sv | 182 ++++++++++++++++++
 tb/tb_modexp_ladder.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/modexp_ladder_if.sv
// Bus between the exponentiation ladder and its two Montgomery multipliers.
// The ladder is the master: it issues operands and start pulses, and the
// multipliers answer with done pulses and results.
interface modexp_ladder_if #(
    parameter int unsigned WIDTH = 1024
);
    logic             m0_start;
    logic [WIDTH-1:0] m0_a;
    logic [WIDTH-1:0] m0_b;
    logic             m0_done;
    logic [WIDTH-1:0] m0_result;

    logic             m1_start;
    logic [WIDTH-1:0] m1_a;
    logic [WIDTH-1:0] m1_b;
    logic             m1_done;
    logic [WIDTH-1:0] m1_result;

    modport master (
        output m0_start, m0_a, m0_b, m1_start, m1_a, m1_b,
        input  m0_done, m0_result, m1_done, m1_result
    );

    modport slave (
        input  m0_start, m0_a, m0_b, m1_start, m1_a, m1_b,
        output m0_done, m0_result, m1_done, m1_result
    );
endinterface

// File: rtl/modexp_ladder.sv
// Montgomery-ladder modular exponentiation controller.
// A holds x^k and X holds x^(k+1), both in Montgomery form. Each ladder step
// issues one multiply on each multiplier in parallel. The run is bracketed by
// a conversion into Montgomery form (x * R^2) and one out of it (A * 1).
module modexp_ladder #(
    parameter int unsigned WIDTH = 1024,
    parameter int unsigned ELEN  = 32,
    parameter int unsigned LW    = $clog2(ELEN + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_r,
    input  logic [WIDTH-1:0] in_r2,
    input  logic [ELEN-1:0]  in_e,
    input  logic [LW-1:0]    in_elen,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    modexp_ladder_if.master  mul
);

    typedef enum logic [2:0] {
        StIdle, StInit, StInitWait, StStep, StStepWait, StFinal, StFinalWait, StDone
    } state_t;

    localparam logic [LW-1:0]    ELEN_L = LW'(ELEN);
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

    state_t            state;
    logic [WIDTH-1:0]  acc_a;
    logic [WIDTH-1:0]  acc_x;
    logic [ELEN-1:0]   e_val;
    logic [LW-1:0]     elen;
    logic [LW-1:0]     idx;
    logic              bit_cur;
    logic              flag0;
    logic              flag1;

    logic [WIDTH-1:0]  a_nx;
    logic [WIDTH-1:0]  x_nx;
    logic [LW-1:0]     idx_nx;
    logic [ELEN-1:0]   e_shift;
    logic              bit_nx;
    logic              both;

    // Next A/X: results are folded in the cycle their done arrives, because
    // a result is only valid while its done is high.
    always_comb begin
        a_nx = acc_a;
        x_nx = acc_x;
        case (state)
            StInitWait: begin
                if (mul.m1_done) x_nx = mul.m1_result;
            end
            StStepWait: begin
                if (mul.m0_done) begin
                    if (bit_cur) a_nx = mul.m0_result;
                    else         x_nx = mul.m0_result;
                end
                if (mul.m1_done) begin
                    if (bit_cur) x_nx = mul.m1_result;
                    else         a_nx = mul.m1_result;
                end
            end
            default: ;
        endcase
    end

    // Exponent bit for the next step: first step uses elen-1, later ones idx-1.
    assign idx_nx  = (state == StInitWait) ? elen - LW'(1) : idx - LW'(1);
    assign e_shift = e_val >> idx_nx;
    assign bit_nx  = e_shift[0];
    assign both    = (flag0 | mul.m0_done) & (flag1 | mul.m1_done);

    // Main FSM; start pulses and operands are registered on entry to the
    // issuing state so they are valid exactly while in INIT, STEP or FINAL.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= StIdle;
            busy         <= 1'b0;
            done         <= 1'b0;
            result       <= '0;
            acc_a        <= '0;
            acc_x        <= '0;
            e_val        <= '0;
            elen         <= '0;
            idx          <= '0;
            bit_cur      <= 1'b0;
            flag0        <= 1'b0;
            flag1        <= 1'b0;
            mul.m0_start <= 1'b0;
            mul.m1_start <= 1'b0;
            mul.m0_a     <= '0;
            mul.m0_b     <= '0;
            mul.m1_a     <= '0;
            mul.m1_b     <= '0;
        end else begin
            mul.m0_start <= 1'b0;
            mul.m1_start <= 1'b0;
            done         <= 1'b0;
            acc_a        <= a_nx;
            acc_x        <= x_nx;
            case (state)
                StIdle: begin
                    if (start) begin
                        e_val        <= in_e;
                        elen         <= (in_elen > ELEN_L) ? ELEN_L : in_elen;
                        acc_a        <= in_r;
                        mul.m1_a     <= in_x;
                        mul.m1_b     <= in_r2;
                        mul.m1_start <= 1'b1;
                        busy         <= 1'b1;
                        state        <= StInit;
                    end
                end
                StInit: state <= StInitWait;
                StInitWait: begin
                    if (mul.m1_done) begin
                        if (elen != '0) begin
                            idx          <= idx_nx;
                            bit_cur      <= bit_nx;
                            mul.m0_a     <= a_nx;
                            mul.m0_b     <= x_nx;
                            mul.m1_a     <= bit_nx ? x_nx : a_nx;
                            mul.m1_b     <= bit_nx ? x_nx : a_nx;
                            mul.m0_start <= 1'b1;
                            mul.m1_start <= 1'b1;
                            state        <= StStep;
                        end else begin
                            mul.m0_a     <= a_nx;
                            mul.m0_b     <= ONE;
                            mul.m0_start <= 1'b1;
                            state        <= StFinal;
                        end
                    end
                end
                StStep: state <= StStepWait;
                StStepWait: begin
                    if (both) begin
                        flag0 <= 1'b0;
                        flag1 <= 1'b0;
                        if (idx == '0) begin
                            mul.m0_a     <= a_nx;
                            mul.m0_b     <= ONE;
                            mul.m0_start <= 1'b1;
                            state        <= StFinal;
                        end else begin
                            idx          <= idx_nx;
                            bit_cur      <= bit_nx;
                            mul.m0_a     <= a_nx;
                            mul.m0_b     <= x_nx;
                            mul.m1_a     <= bit_nx ? x_nx : a_nx;
                            mul.m1_b     <= bit_nx ? x_nx : a_nx;
                            mul.m0_start <= 1'b1;
                            mul.m1_start <= 1'b1;
                            state        <= StStep;
                        end
                    end else begin
                        flag0 <= flag0 | mul.m0_done;
                        flag1 <= flag1 | mul.m1_done;
                    end
                end
                StFinal: state <= StFinalWait;
                StFinalWait: begin
                    if (mul.m0_done) begin
                        result <= mul.m0_result;
                        done   <= 1'b1;
                        state  <= StDone;
                    end
                end
                StDone: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_modexp_ladder.sv
// Directed bench for modexp_ladder with N=239, R=256 and two behavioural
// Montgomery multipliers (a*b*R^-1 mod N, latency 5 unless skewed).
module tb_modexp_ladder;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned ELEN  = 8;
    localparam int unsigned LW    = 4;

    logic             clk = 1'b0;
    logic             resetn;
    logic             start;
    logic [WIDTH-1:0] in_x;
    logic [WIDTH-1:0] in_r;
    logic [WIDTH-1:0] in_r2;
    logic [ELEN-1:0]  in_e;
    logic [LW-1:0]    in_elen;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    int checks = 0;
    int passes = 0;

    int   cnt0 = 0;
    int   cnt1 = 0;
    int   n0 = 0;
    int   rounds = 0;
    int   done_cnt = 0;
    bit   skew = 1'b0;
    logic [7:0] pa0, pb0, pa1, pb1;

    modexp_ladder_if #(.WIDTH(WIDTH)) mif ();

    modexp_ladder #(.WIDTH(WIDTH), .ELEN(ELEN), .LW(LW)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .start   (start),
        .in_x    (in_x),
        .in_r    (in_r),
        .in_r2   (in_r2),
        .in_e    (in_e),
        .in_elen (in_elen),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .mul     (mif)
    );

    always #5 clk = ~clk;

    // t such that t*R == a*b (mod N), found by search
    function automatic logic [7:0] mont(input int a, input int b);
        int p;
        p = (a * b) % 239;
        for (int t = 0; t < 239; t++) begin
            if ((t * 256) % 239 == p) return 8'(t);
        end
        return 8'd0;
    endfunction

    // Multiplier models; results read as zero whenever done is low
    always @(negedge clk) begin
        mif.m0_done = 1'b0;
        mif.m0_result = 8'd0;
        mif.m1_done = 1'b0;
        mif.m1_result = 8'd0;
        if (cnt0 > 0) begin
            cnt0--;
            if (cnt0 == 0) begin
                mif.m0_done = 1'b1;
                mif.m0_result = mont(int'(pa0), int'(pb0));
            end
        end
        if (cnt1 > 0) begin
            cnt1--;
            if (cnt1 == 0) begin
                mif.m1_done = 1'b1;
                mif.m1_result = mont(int'(pa1), int'(pb1));
            end
        end
        if (mif.m0_start) begin
            pa0 = mif.m0_a;
            pb0 = mif.m0_b;
            n0++;
            cnt0 = (skew && (n0 % 2 == 1)) ? 8 : 5;
        end
        if (mif.m1_start) begin
            pa1 = mif.m1_a;
            pb1 = mif.m1_b;
            cnt1 = 5;
        end
        if (mif.m0_start || mif.m1_start) rounds++;
        if (done) done_cnt++;
    end

    task automatic clear_counts();
        rounds = 0;
        done_cnt = 0;
        n0 = 0;
    endtask

    task automatic pulse_start(input logic [7:0] x, input logic [7:0] e, input logic [3:0] l);
        in_x = x;
        in_e = e;
        in_elen = l;
        in_r = 8'd17;
        in_r2 = 8'd50;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (done) ok = 1'b1;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_rounds(input int n);
        for (int i = 0; i < 100 && rounds < n; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        start = 1'b0;
        in_x = '0; in_r = '0; in_r2 = '0; in_e = '0; in_elen = '0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passes++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passes++;
        checks++; if (result !== 8'd0) $display("FAIL reset_result got %0d want 0", result); else passes++;
        checks++;
        if ({mif.m0_start, mif.m1_start} !== 2'b00)
            $display("FAIL reset_starts got %b want 00", {mif.m0_start, mif.m1_start});
        else passes++;
        checks++;
        if ({mif.m0_a, mif.m0_b, mif.m1_a, mif.m1_b} !== 32'd0)
            $display("FAIL reset_operands got %h want 0", {mif.m0_a, mif.m0_b, mif.m1_a, mif.m1_b});
        else passes++;
        resetn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        bit ok;
        clear_counts();
        pulse_start(8'd5, 8'd3, 4'd2);
        wait_done(ok);
        checks++; if (ok !== 1'b1) $display("FAIL basic_done_seen got %b want 1", ok); else passes++;
        checks++; if (result !== 8'd125) $display("FAIL basic_result got %0d want 125", result); else passes++;
        checks++; if (done_cnt !== 1) $display("FAIL basic_done_count got %0d want 1", done_cnt); else passes++;
        checks++; if (rounds !== 4) $display("FAIL basic_rounds got %0d want 4", rounds); else passes++;
        repeat (5) @(negedge clk);
        checks++; if (result !== 8'd125) $display("FAIL basic_hold got %0d want 125", result); else passes++;
    endtask

    task automatic test_zero_len();
        bit ok;
        clear_counts();
        pulse_start(8'd7, 8'hff, 4'd0);
        wait_done(ok);
        checks++; if (ok !== 1'b1) $display("FAIL zero_done_seen got %b want 1", ok); else passes++;
        checks++; if (result !== 8'd1) $display("FAIL zero_result got %0d want 1", result); else passes++;
        checks++; if (rounds !== 2) $display("FAIL zero_rounds got %0d want 2", rounds); else passes++;
    endtask

    task automatic test_skew();
        bit ok;
        clear_counts();
        skew = 1'b1;
        pulse_start(8'd2, 8'd10, 4'd4);
        wait_done(ok);
        skew = 1'b0;
        checks++; if (ok !== 1'b1) $display("FAIL skew_done_seen got %b want 1", ok); else passes++;
        checks++; if (result !== 8'd68) $display("FAIL skew_result got %0d want 68", result); else passes++;
        checks++; if (rounds !== 6) $display("FAIL skew_rounds got %0d want 6", rounds); else passes++;
    endtask

    task automatic test_start_busy();
        bit ok;
        clear_counts();
        pulse_start(8'd3, 8'd5, 4'd3);
        wait_rounds(2);
        @(negedge clk);
        in_x = 8'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(ok);
        checks++; if (ok !== 1'b1) $display("FAIL busy_done_seen got %b want 1", ok); else passes++;
        checks++; if (result !== 8'd4) $display("FAIL busy_result got %0d want 4", result); else passes++;
        checks++; if (rounds !== 5) $display("FAIL busy_rounds got %0d want 5", rounds); else passes++;
        repeat (20) @(negedge clk);
        checks++; if (done_cnt !== 1) $display("FAIL busy_done_count got %0d want 1", done_cnt); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL busy_idle_after got %b want 0", busy); else passes++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_counts();
        pulse_start(8'd4, 8'd3, 4'd2);
        wait_rounds(2);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy); else passes++;
        checks++; if (result !== 8'd0) $display("FAIL midrst_result got %0d want 0", result); else passes++;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (20) @(negedge clk);
        checks++; if (done_cnt !== 0) $display("FAIL midrst_no_done got %0d want 0", done_cnt); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL midrst_stray_done got busy %b want 0", busy); else passes++;
        clear_counts();
        pulse_start(8'd4, 8'd3, 4'd2);
        wait_done(ok);
        checks++; if (result !== 8'd64) $display("FAIL midrst_rerun got %0d want 64", result); else passes++;
        checks++; if (done_cnt !== 1) $display("FAIL midrst_rerun_done got %0d want 1", done_cnt); else passes++;
    endtask

    task automatic test_clamp();
        bit ok;
        clear_counts();
        pulse_start(8'd2, 8'd3, 4'hf);
        wait_done(ok);
        checks++; if (ok !== 1'b1) $display("FAIL clamp_done_seen got %b want 1", ok); else passes++;
        checks++; if (result !== 8'd8) $display("FAIL clamp_result got %0d want 8", result); else passes++;
        checks++; if (rounds !== 10) $display("FAIL clamp_rounds got %0d want 10", rounds); else passes++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_skew();
        test_start_busy();
        test_reset_mid();
        test_clamp();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
